// File: rtl/example_ctrl_pkg.sv
// Shared definitions for the example register access controller:
// FSM state encoding and the mask of registers that have no reset value.
package example_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Bit n set: register n has no reset value and tracks a written flag.
    localparam logic [7:0] UNRESET_MASK = 8'b0110_0000;

endpackage

// File: rtl/example_sv_pkg.sv
// Register-bank description for the "example" bank: addresses, field layout
// and the access functions (reset, read, write) used by the access controller.
//   read_example  : register contents + address -> zero-extended read data
//   write_example : write data + address + contents -> updated contents
//   reset_example : reset contents (reg5/reg6 have no reset value; callers keep them)
package example_sv_pkg;

    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG2_WIDTH = 6;
    localparam int unsigned REG7_WIDTH = 12;

    localparam logic [ADDR_WIDTH-1:0] REG0_ADDR = 3'd0;
    localparam logic [ADDR_WIDTH-1:0] REG1_ADDR = 3'd1;
    localparam logic [ADDR_WIDTH-1:0] REG2_ADDR = 3'd2;
    localparam logic [ADDR_WIDTH-1:0] REG3_ADDR = 3'd3;
    localparam logic [ADDR_WIDTH-1:0] REG4_ADDR = 3'd4;
    localparam logic [ADDR_WIDTH-1:0] REG5_ADDR = 3'd5;
    localparam logic [ADDR_WIDTH-1:0] REG6_ADDR = 3'd6;
    localparam logic [ADDR_WIDTH-1:0] REG7_ADDR = 3'd7;

    typedef struct packed {
        logic [3:0] nibble2;
        logic [3:0] nibble1;
        logic [3:0] nibble0;
    } reg7_t;

    typedef struct packed {
        reg7_t                 reg7;
        logic [DATA_WIDTH-1:0] reg6;
        logic [DATA_WIDTH-1:0] reg5;
        logic [DATA_WIDTH-1:0] reg4;
        logic [DATA_WIDTH-1:0] reg3;
        logic [REG2_WIDTH-1:0] reg2;
        logic [DATA_WIDTH-1:0] reg1;
        logic [DATA_WIDTH-1:0] reg0;
    } example_struct_type;

    // Reset image of the bank; reg5/reg6 are don't-care here.
    function automatic example_struct_type reset_example();
        example_struct_type r;
        r      = '0;
        r.reg1 = 32'h0000_0001;
        r.reg3 = 32'h0000_0001;
        r.reg4 = 32'h0000_000C;
        return r;
    endfunction

    // Narrow registers are zero-extended onto the data bus.
    function automatic logic [DATA_WIDTH-1:0] read_example(
        input example_struct_type    regs,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] rdata;
        rdata = '0;
        case (addr)
            REG0_ADDR: rdata = regs.reg0;
            REG1_ADDR: rdata = regs.reg1;
            REG2_ADDR: rdata = DATA_WIDTH'(regs.reg2);
            REG3_ADDR: rdata = regs.reg3;
            REG4_ADDR: rdata = regs.reg4;
            REG5_ADDR: rdata = regs.reg5;
            REG6_ADDR: rdata = regs.reg6;
            REG7_ADDR: rdata = DATA_WIDTH'(regs.reg7);
            default:   rdata = '0;
        endcase
        return rdata;
    endfunction

    // Narrow registers take the low bits of the write data.
    function automatic example_struct_type write_example(
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [ADDR_WIDTH-1:0] addr,
        input example_struct_type    regs
    );
        example_struct_type w;
        w = regs;
        case (addr)
            REG0_ADDR: w.reg0 = wdata;
            REG1_ADDR: w.reg1 = wdata;
            REG2_ADDR: w.reg2 = wdata[REG2_WIDTH-1:0];
            REG3_ADDR: w.reg3 = wdata;
            REG4_ADDR: w.reg4 = wdata;
            REG5_ADDR: w.reg5 = wdata;
            REG6_ADDR: w.reg6 = wdata;
            REG7_ADDR: w.reg7 = reg7_t'(wdata[REG7_WIDTH-1:0]);
            default:   w      = regs;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/example_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
//   valid       in   NUM_REQ   request valid vector
//   ptr         in   IDX_W     highest-priority requester
//   winner_c    out  IDX_W     selected requester (meaningful when any_valid_c)
//   any_valid_c out  1         at least one valid request
module example_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner_c,
    output logic               any_valid_c
);

    // Scan NUM_REQ positions starting at ptr; first hit wins.
    always_comb begin
        int unsigned idx;
        winner_c    = '0;
        any_valid_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid_c && valid[idx]) begin
                winner_c    = IDX_W'(idx);
                any_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/example_reg_ctrl.sv
// Multi-requester access controller for the "example" register bank.
// Owns the register storage and serialises round-robin arbitrated
// read/write requests, one transaction every three cycles (IDLE/ACCESS/RESP).
//   clk, reset_n  clock, synchronous active-low reset
//   req_valid/req_we/req_addr/req_wdata  per-requester request
//   req_ready     one-hot accept pulse (ACCESS cycle)
//   rsp_valid     one-hot response pulse (RESP cycle)
//   rsp_rdata     read data (0 for writes), held outside RESP
//   rsp_err       read of an unreset register not yet written
//   regs_o        current register contents
module example_reg_ctrl
    import example_sv_pkg::*;
    import example_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned RR_RESET_PTR = 0
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0]                     req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [DATA_WIDTH-1:0]                  rsp_rdata,
    output logic                                   rsp_err,
    output example_struct_type                     regs_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    example_struct_type      regs_q, regs_d, regs_rst_c;
    logic [7:0]              written_q, written_d;

    logic [IDX_W-1:0]        winner_c;
    logic                    any_valid_c;

    example_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid       (req_valid),
        .ptr         (rr_ptr_q),
        .winner_c    (winner_c),
        .any_valid_c (any_valid_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid_c) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values. Handshake outputs are computed one state
    // early so the registered pulses land in ACCESS and RESP respectively.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        regs_d      = regs_q;
        written_d   = written_q;
        case (state_q)
            IDLE: begin
                if (any_valid_c) begin
                    win_d                 = winner_c;
                    we_d                  = req_we[winner_c];
                    addr_d                = req_addr[winner_c];
                    wdata_d               = req_wdata[winner_c];
                    req_ready_d[winner_c] = 1'b1;
                end
            end
            ACCESS: begin
                rsp_valid_d[win_q] = 1'b1;
                if (we_q) begin
                    regs_d            = write_example(wdata_q, addr_q, regs_q);
                    written_d[addr_q] = written_q[addr_q] | UNRESET_MASK[addr_q];
                    rsp_rdata_d       = '0;
                    rsp_err_d         = 1'b0;
                end else begin
                    rsp_rdata_d = read_example(regs_q, addr_q);
                    rsp_err_d   = UNRESET_MASK[addr_q] & ~written_q[addr_q];
                end
            end
            RESP: begin
                if (32'(win_q) + 32'd1 >= NUM_REQ) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_q + IDX_W'(1);
                end
            end
            default: begin
                req_ready_d = '0;
            end
        endcase
    end

    // Reset image keeps the unreset registers' current contents.
    always_comb begin
        regs_rst_c      = reset_example();
        regs_rst_c.reg5 = regs_q.reg5;
        regs_rst_c.reg6 = regs_q.reg6;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q    <= IDX_W'(RR_RESET_PTR);
            win_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            regs_q      <= regs_rst_c;
            written_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            regs_q      <= regs_d;
            written_q   <= written_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign regs_o    = regs_q;

endmodule

// File: tb/tb_example_reg_ctrl.sv
// Directed self-checking bench for example_reg_ctrl (NUM_REQ = 2).
module tb_example_reg_ctrl;
    import example_sv_pkg::*;

    localparam int unsigned NUM_REQ = 2;

    logic                              clk = 1'b0;
    logic                              reset_n;
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_we;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [DATA_WIDTH-1:0]             rsp_rdata;
    logic                              rsp_err;
    example_struct_type                regs_o;

    int checks = 0;
    int errors = 0;

    example_reg_ctrl #(
        .NUM_REQ      (NUM_REQ),
        .RR_RESET_PTR (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .regs_o    (regs_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for any req_ready; called and returns at posedge+1.
    task automatic wait_ready(output logic [NUM_REQ-1:0] rdy);
        rdy = '0;
        for (int c = 0; c < 10 && rdy == '0; c++) begin
            @(posedge clk); #1;
            rdy = req_ready;
        end
    endtask

    // Single-requester transaction; returns in the RESP cycle.
    task automatic txn(input int r, input logic we, input logic [2:0] addr,
                       input logic [31:0] wdata, input string tag,
                       output logic [31:0] rdata, output logic err, output int lat);
        bit got;
        got          = 1'b0;
        lat          = 0;
        req_valid[r] = 1'b1;
        req_we[r]    = we;
        req_addr[r]  = addr;
        req_wdata[r] = wdata;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            if (req_ready[r]) got = 1'b1;
        end
        req_valid[r] = 1'b0;
        check({tag, " ready"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1 << r));
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    initial begin
        logic [31:0]        rd;
        logic               er;
        int                 lat;
        logic [NUM_REQ-1:0] rdy;
        int                 order [4];
        int                 exp_order [4];
        int                 n_ready, n_rsp, last_rsp;
        bit                 both, spacing_bad, ready_bad;

        exp_order = '{0, 1, 0, 1};
        reset_n   = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst reg4", regs_o.reg4, 32'h0000_000C);
        reset_n = 1'b1;

        // 1. Reads of reset values, latency
        txn(0, 1'b0, REG4_ADDR, 32'd0, "rd reg4", rd, er, lat);
        check("rd reg4 latency", 32'(lat), 32'd1);
        check("rd reg4 data", rd, 32'h0000_000C);
        check("rd reg4 err", 32'(er), 32'd0);
        txn(0, 1'b0, REG1_ADDR, 32'd0, "rd reg1", rd, er, lat);
        check("rd reg1 latency", 32'(lat), 32'd2);
        check("rd reg1 data", rd, 32'h0000_0001);
        check("rd reg1 err", 32'(er), 32'd0);

        // 2. Unwritten reg5, then write/read
        txn(0, 1'b0, REG5_ADDR, 32'd0, "rd reg5 unwritten", rd, er, lat);
        check("rd reg5 unwritten err", 32'(er), 32'd1);
        txn(0, 1'b1, REG5_ADDR, 32'hDEAD_BEEF, "wr reg5", rd, er, lat);
        check("wr reg5 rdata", rd, 32'd0);
        check("wr reg5 err", 32'(er), 32'd0);
        txn(0, 1'b0, REG5_ADDR, 32'd0, "rd reg5", rd, er, lat);
        check("rd reg5 data", rd, 32'hDEAD_BEEF);
        check("rd reg5 err", 32'(er), 32'd0);

        // 3. Narrow registers
        txn(1, 1'b1, REG2_ADDR, 32'hFFFF_FFFF, "wr reg2", rd, er, lat);
        txn(1, 1'b0, REG2_ADDR, 32'd0, "rd reg2", rd, er, lat);
        check("rd reg2 data", rd, 32'h0000_003F);
        txn(0, 1'b1, REG7_ADDR, 32'h000F_0F0F, "wr reg7", rd, er, lat);
        check("reg7 nibble2", 32'(regs_o.reg7.nibble2), 32'hF);
        check("reg7 nibble1", 32'(regs_o.reg7.nibble1), 32'h0);
        check("reg7 nibble0", 32'(regs_o.reg7.nibble0), 32'hF);
        txn(0, 1'b0, REG7_ADDR, 32'd0, "rd reg7", rd, er, lat);
        check("rd reg7 data", rd, 32'h0000_0F0F);

        // 4. Both requesters hold valid: round robin from pointer 0
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n      = 1'b1;
        req_we       = '0;
        req_addr[0]  = REG0_ADDR;
        req_addr[1]  = REG1_ADDR;
        req_valid    = 2'b11;
        n_ready      = 0;
        n_rsp        = 0;
        last_rsp     = -1;
        both         = 1'b0;
        spacing_bad  = 1'b0;
        ready_bad    = 1'b0;
        order        = '{-1, -1, -1, -1};
        for (int c = 0; c < 20 && n_rsp < 4; c++) begin
            @(posedge clk); #1;
            if (req_ready != '0) begin
                if ($countones(req_ready) != 1) ready_bad = 1'b1;
                if (n_ready < 4) order[n_ready] = req_ready[1] ? 1 : 0;
                n_ready++;
                if (n_ready == 4) req_valid = '0;
            end
            if (rsp_valid == 2'b11) both = 1'b1;
            if (rsp_valid != '0) begin
                if (last_rsp >= 0 && c - last_rsp != 3) spacing_bad = 1'b1;
                check("rr rsp data", rsp_rdata, rsp_valid[1] ? 32'd1 : 32'd0);
                last_rsp = c;
                n_rsp++;
            end
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr order %0d", i), 32'(order[i]), 32'(exp_order[i]));
        end
        check("rr rsp count", 32'(n_rsp), 32'd4);
        check("rr rsp both set", 32'(both), 32'd0);
        check("rr rsp spacing", 32'(spacing_bad), 32'd0);
        check("rr ready onehot", 32'(ready_bad), 32'd0);

        // 5. Simultaneous read/write of reg3, pointer back at 0
        req_we       = 2'b10;
        req_addr[0]  = REG3_ADDR;
        req_addr[1]  = REG3_ADDR;
        req_wdata[1] = 32'h1234_5678;
        req_valid    = 2'b11;
        wait_ready(rdy);
        check("ser first ready", 32'(rdy), 32'b01);
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("ser first rsp_valid", 32'(rsp_valid), 32'b01);
        check("ser first rdata", rsp_rdata, 32'h0000_0001);
        wait_ready(rdy);
        check("ser second ready", 32'(rdy), 32'b10);
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("ser second rsp_valid", 32'(rsp_valid), 32'b10);
        txn(0, 1'b0, REG3_ADDR, 32'd0, "ser rd reg3", rd, er, lat);
        check("ser rd reg3 data", rd, 32'h1234_5678);

        // 6. Reset during ACCESS of a write
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = REG0_ADDR;
        req_wdata[0] = 32'h0000_0055;
        wait_ready(rdy);
        check("abort ready", 32'(rdy), 32'b01);
        reset_n   = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        check("abort rsp_valid 1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("abort rsp_valid 2", 32'(rsp_valid), 32'd0);
        check("abort regs reg0", regs_o.reg0, 32'd0);
        check("abort reg5 held", regs_o.reg5, 32'hDEAD_BEEF);
        reset_n = 1'b1;
        txn(0, 1'b0, REG0_ADDR, 32'd0, "abort rd reg0", rd, er, lat);
        check("abort rd reg0 data", rd, 32'd0);
        txn(1, 1'b0, REG5_ADDR, 32'd0, "abort rd reg5", rd, er, lat);
        check("abort rd reg5 err", 32'(er), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
